shift_accumulator: RTL and testbench



---
 rtl/dsp_pkg.sv | 18 +
 rtl/shift_accumulator_if.sv | 27 ++
 rtl/shift_accumulator_sat.sv | 23 ++
 rtl/shift_accumulator.sv | 94 +++++++++
 tb/tb_shift_accumulator.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dsp_pkg.sv
// dsp_pkg: shared types, default sizes and saturation helper for the shift-add datapath.
package dsp_pkg;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_GUARD     = 8;
    localparam int DEF_MAX_TERMS = 16;
    localparam int ACC_W         = DEF_WIDTH + DEF_GUARD;

    typedef enum logic {ACCUM, HOLD} state_e;

    // Clamp a signed value to the range of a signed integer of the given width.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        return (value > hi) ? hi : (value < lo) ? lo : value;
    endfunction
endpackage

// File: rtl/shift_accumulator_if.sv
// shift_accumulator_if: term input stream and result output port of the accumulator.
interface shift_accumulator_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_term;
    logic             in_sub;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sat;
    logic             out_overrun;
    logic [CW-1:0]    out_count;

    modport master (
        output in_valid, in_term, in_sub, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_overrun, out_count
    );

    modport slave (
        input  in_valid, in_term, in_sub, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_overrun, out_count
    );
endinterface

// File: rtl/shift_accumulator_sat.sv
// sat_clamp_unit: saturates a wide signed value to a narrower signed result and flags clamping.
module sat_clamp_unit import dsp_pkg::*; #(
    parameter int IW = ACC_W,
    parameter int OW = DEF_WIDTH
) (
    input  logic signed [IW-1:0] value_i,
    output logic        [OW-1:0] data_o,
    output logic                 sat_o
);
    if (IW > 64 || OW > IW) begin : g_bad_width
        $error("sat_clamp_unit: IW must be <= 64 and OW <= IW");
    end

    logic signed [63:0] wide;
    logic signed [63:0] clamped;

    always_comb begin
        wide    = 64'(value_i);
        clamped = sat_clamp(wide, OW);
        data_o  = clamped[OW-1:0];
        sat_o   = clamped != wide;
    end
endmodule

// File: rtl/shift_accumulator.sv
// shift_accumulator: guarded add/subtract accumulator over framed terms with a saturated
// valid/ready result port.
module shift_accumulator import dsp_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int GUARD     = DEF_GUARD,
    parameter int MAX_TERMS = DEF_MAX_TERMS
) (
    input logic                clk,
    input logic                reset,
    shift_accumulator_if.slave s_if
);
    localparam int AW = WIDTH + GUARD;
    localparam int CW = $clog2(MAX_TERMS + 1);

    // Guard bits must cover the worst-case growth of a full frame.
    if (MAX_TERMS > (1 << GUARD)) begin : g_bad_guard
        $error("shift_accumulator: MAX_TERMS exceeds 2**GUARD, accumulator could wrap");
    end

    state_e               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 sat_q, sat_d;
    logic                 ovr_q, ovr_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic signed [AW-1:0] term_ext;
    logic signed [AW-1:0] term_x;
    logic signed [AW-1:0] next_acc;
    logic [CW-1:0]        next_count;
    logic                 accept;
    logic                 close;
    logic                 release_hold;
    logic [WIDTH-1:0]     clamp_data;
    logic                 clamp_sat;

    assign accept       = s_if.in_valid && state_q == ACCUM;
    assign release_hold = state_q == HOLD && s_if.out_ready;
    assign term_ext     = {{GUARD{s_if.in_term[WIDTH-1]}}, s_if.in_term};
    assign term_x       = s_if.in_sub ? -term_ext : term_ext;
    assign next_acc     = (count_q == '0 ? '0 : acc_q) + term_x;
    assign next_count   = count_q + 1'b1;
    assign close        = accept && (s_if.in_last || next_count == CW'(MAX_TERMS));

    sat_clamp_unit #(.IW(AW), .OW(WIDTH)) u_clamp (
        .value_i (next_acc),
        .data_o  (clamp_data),
        .sat_o   (clamp_sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ACCUM;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == ACCUM) ? (close ? HOLD : ACCUM) : (s_if.out_ready ? ACCUM : HOLD);
    end

    always_comb begin
        acc_d   = (accept && !close) ? next_acc : release_hold ? '0 : acc_q;
        count_d = (accept && !close) ? next_count : release_hold ? '0 : count_q;
        data_d  = close ? clamp_data : data_q;
        sat_d   = close ? clamp_sat : sat_q;
        ovr_d   = close ? !s_if.in_last : ovr_q;
        cnt_d   = close ? next_count : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_if.in_ready    = state_q == ACCUM;
    assign s_if.out_valid   = state_q == HOLD;
    assign s_if.out_data    = data_q;
    assign s_if.out_sat     = sat_q;
    assign s_if.out_overrun = ovr_q;
    assign s_if.out_count   = cnt_q;
endmodule

// File: tb/tb_shift_accumulator.sv
// tb_shift_accumulator: table-driven frames plus hand sequences, results checked through a scoreboard.
module tb_shift_accumulator;
    typedef struct {
        logic [31:0] term;
        logic        sub;
        logic        last;
        logic        closes;
        logic [31:0] data;
        logic        sat;
        logic        ovr;
        logic [4:0]  cnt;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        sat;
        logic        ovr;
        logic [4:0]  cnt;
    } res_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    res_t exp_q[$];
    vec_t vecs[$];

    shift_accumulator_if #(.WIDTH(32), .CW(5)) bus ();

    shift_accumulator dut (
        .clk   (clk),
        .reset (reset),
        .s_if  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic send(input logic [31:0] t, input logic s, input logic l);
        int n;
        n = 0;
        bus.in_term  = t;
        bus.in_sub   = s;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 50);
        if (!bus.in_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high term=%h", t);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
        chk({tag, "_out_sat"}, 64'(bus.out_sat), 64'd0);
        chk({tag, "_out_overrun"}, 64'(bus.out_overrun), 64'd0);
        chk({tag, "_out_count"}, 64'(bus.out_count), 64'd0);
    endtask

    always @(negedge clk) begin
        res_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_result actual=%h required=no_output", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 64'(bus.out_data), 64'(e.data));
                chk("out_sat", 64'(bus.out_sat), 64'(e.sat));
                chk("out_overrun", 64'(bus.out_overrun), 64'(e.ovr));
                chk("out_count", 64'(bus.out_count), 64'(e.cnt));
            end
        end
    end

    initial begin
        int n;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_term   = '0;
        bus.in_sub    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        chk_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        vecs.push_back('{32'hFFFABCD0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 5'd0});
        vecs.push_back('{32'h01234000, 1'b0, 1'b1, 1'b1, 32'h011DFCD0, 1'b0, 1'b0, 5'd2});
        vecs.push_back('{32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 5'd0});
        vecs.push_back('{32'h00000001, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 5'd2});
        vecs.push_back('{32'h80000000, 1'b1, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 5'd1});
        vecs.push_back('{32'h80000000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 5'd0});
        vecs.push_back('{32'h00000001, 1'b1, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b0, 5'd2});
        vecs.push_back('{32'h00000064, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 5'd0});
        vecs.push_back('{32'h0000001E, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 5'd0});
        vecs.push_back('{32'h00000005, 1'b1, 1'b1, 1'b1, 32'h00000041, 1'b0, 1'b0, 5'd3});
        vecs.push_back('{32'h00000010, 1'b1, 1'b1, 1'b1, 32'hFFFFFFF0, 1'b0, 1'b0, 5'd1});
        vecs.push_back('{32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 5'd0});
        vecs.push_back('{32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 5'd0});
        vecs.push_back('{32'h80000000, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFE, 1'b0, 1'b0, 5'd3});

        foreach (vecs[i]) begin
            if (vecs[i].closes) exp_q.push_back('{vecs[i].data, vecs[i].sat, vecs[i].ovr, vecs[i].cnt});
            send(vecs[i].term, vecs[i].sub, vecs[i].last);
        end

        send(32'h00000010, 1'b0, 1'b0);
        chk("latency_valid_before_close", 64'(bus.out_valid), 64'd0);
        exp_q.push_back('{32'h00000030, 1'b0, 1'b0, 5'd2});
        send(32'h00000020, 1'b0, 1'b1);
        chk("latency_valid_after_close", 64'(bus.out_valid), 64'd1);
        chk("latency_in_ready_hold", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("latency_valid_dropped", 64'(bus.out_valid), 64'd0);
        chk("latency_in_ready_back", 64'(bus.in_ready), 64'd1);

        bus.out_ready = 1'b0;
        exp_q.push_back('{32'h00000003, 1'b0, 1'b0, 5'd1});
        send(32'h00000003, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_term  = 32'h00000005;
        bus.in_sub   = 1'b0;
        bus.in_last  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_out_data", 64'(bus.out_data), 64'h3);
            chk("bp_out_count", 64'(bus.out_count), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'h00000007, 1'b0, 1'b0);
        exp_q.push_back('{32'h00000008, 1'b0, 1'b0, 5'd2});
        send(32'h00000001, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            if (i == 15) exp_q.push_back('{32'h00000010, 1'b0, 1'b1, 5'd16});
            send(32'h00000001, 1'b0, 1'b0);
        end
        exp_q.push_back('{32'h00000001, 1'b0, 1'b0, 5'd1});
        send(32'h00000001, 1'b0, 1'b1);

        repeat (3) send(32'h00001000, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("midframe_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back('{32'h00000002, 1'b0, 1'b0, 5'd1});
        send(32'h00000002, 1'b0, 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain actual=%0d_pending required=0_pending", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
